// File: rtl/regfile_pkg.sv
// Purpose : shared types, constants and helpers for the multi-port register file.
// Contents: clog2 width helper, init FSM state enum, hardwired-zero entry index.
package regfile_pkg;

  localparam int unsigned RF_ZERO_IDX = 0;

  typedef enum logic {
    RF_IDLE = 1'b0,
    RF_INIT = 1'b1
  } rf_state_e;

  // Ceiling log2 for elaboration-time width derivation.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Purpose : decode/writeback-side bus of the register file.
// Signals : init_req, ready, rn/q (NRD read ports), we0/wn0/d0 and we1/wn1/d1
//           (two retire lanes), collide.
// Modports: master (decode/writeback side), slave (register file).
interface regfile_mp_if import regfile_pkg::*; #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned NRD  = 2
);
  localparam int unsigned AW = clog2(NREG);

  logic                 init_req;
  logic                 ready;
  logic [NRD*AW-1:0]    rn;
  logic [NRD*XLEN-1:0]  q;
  logic                 we0;
  logic [AW-1:0]        wn0;
  logic [XLEN-1:0]      d0;
  logic                 we1;
  logic [AW-1:0]        wn1;
  logic [XLEN-1:0]      d1;
  logic                 collide;

  modport master (
    output init_req, rn, we0, wn0, d0, we1, wn1, d1,
    input  ready, q, collide
  );

  modport slave (
    input  init_req, rn, we0, wn0, d0, we1, wn1, d1,
    output ready, q, collide
  );

endinterface

// File: rtl/regfile_init_fsm.sv
// Purpose : sequential clear engine; sweeps every entry once after reset or
//           on init_req, then reports ready.
// Ports   : clk, clr (async, active high), init_req,
//           ready, init_we/init_idx (clear write into storage).
module regfile_init_fsm import regfile_pkg::*; #(
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = clog2(NREG)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          init_req,
  output logic          ready,
  output logic          init_we,
  output logic [AW-1:0] init_idx
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);

  rf_state_e     state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;

  // State and sweep counter.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= RF_INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: init_req always restarts the sweep from entry 0.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      RF_IDLE: begin
        if (init_req) begin
          state_nxt = RF_INIT;
          cnt_nxt   = '0;
        end
      end
      RF_INIT: begin
        if (init_req) begin
          cnt_nxt = '0;
        end else if (cnt == LAST_IDX) begin
          state_nxt = RF_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + AW'(1);
        end
      end
      default: begin
        state_nxt = RF_INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    ready    = 1'b0;
    init_we  = 1'b0;
    init_idx = cnt;
    if (state == RF_IDLE) ready   = 1'b1;
    if (state == RF_INIT) init_we = 1'b1;
  end

endmodule

// File: rtl/regfile_mp.sv
// Purpose : NRD-read / 2-write integer register file with optional same-cycle
//           bypass and hardwired zero entry; contents cleared by a sweep engine.
// Ports   : clk, clr (async, active high), bus (regfile_mp_if.slave):
//           init_req/ready, rn/q read ports, lane0/lane1 writes, collide.
module regfile_mp import regfile_pkg::*; #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREG     = 32,
  parameter int unsigned NRD      = 2,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic         clk,
  input  logic         clr,
  regfile_mp_if.slave  bus
);

  localparam int unsigned AW = clog2(NREG);

  logic [XLEN-1:0] mem [NREG];
  logic            ready;
  logic            init_we;
  logic [AW-1:0]   init_idx;
  logic            w0_ok;
  logic            w1_ok;
  logic            collide;

  regfile_init_fsm #(
    .NREG (NREG),
    .AW   (AW)
  ) u_init (
    .clk      (clk),
    .clr      (clr),
    .init_req (bus.init_req),
    .ready    (ready),
    .init_we  (init_we),
    .init_idx (init_idx)
  );

  // Lane qualification: only while ready, and never to the hardwired zero entry.
  always_comb begin
    w0_ok = ready && bus.we0 && !(ZERO_REG && (bus.wn0 == AW'(RF_ZERO_IDX)));
    w1_ok = ready && bus.we1 && !(ZERO_REG && (bus.wn1 == AW'(RF_ZERO_IDX)));
  end

  // Storage write mux: init sweep > lane1 > lane0; no reset on the array.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_idx] <= '0;
    end else begin
      if (w0_ok && !(w1_ok && (bus.wn1 == bus.wn0))) mem[bus.wn0] <= bus.d0;
      if (w1_ok) mem[bus.wn1] <= bus.d1;
    end
  end

  // One-cycle pulse when both accepted lanes hit the same entry.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) collide <= 1'b0;
    else     collide <= w0_ok && w1_ok && (bus.wn0 == bus.wn1);
  end

  assign bus.ready   = ready;
  assign bus.collide = collide;

  // Per-port read mux; lane1 wins over lane0 when both match.
  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] rdata;

    always_comb begin
      idx   = bus.rn[k*AW +: AW];
      rdata = mem[idx];
      if (!ready) begin
        rdata = '0;
      end else if (ZERO_REG && (idx == AW'(RF_ZERO_IDX))) begin
        rdata = '0;
      end else if (BYPASS && w1_ok && (bus.wn1 == idx)) begin
        rdata = bus.d1;
      end else if (BYPASS && w0_ok && (bus.wn0 == idx)) begin
        rdata = bus.d0;
      end
    end

    assign bus.q[k*XLEN +: XLEN] = rdata;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Purpose : self-checking bench for regfile_mp; two instances (32x2 bypass,
//           64x3 no-bypass) checked every cycle against a behavioural model.
module tb_regfile_mp;

  localparam int unsigned NI = 2;

  logic clk = 1'b0;
  logic clr_a;
  logic clr_b;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_mp_if #(.XLEN(32), .NREG(32), .NRD(2)) ifa ();
  regfile_mp_if #(.XLEN(32), .NREG(64), .NRD(3)) ifb ();

  regfile_mp #(.XLEN(32), .NREG(32), .NRD(2), .BYPASS(1'b1), .ZERO_REG(1'b1)) dut_a (
    .clk (clk),
    .clr (clr_a),
    .bus (ifa.slave)
  );

  regfile_mp #(.XLEN(32), .NREG(64), .NRD(3), .BYPASS(1'b0), .ZERO_REG(1'b1)) dut_b (
    .clk (clk),
    .clr (clr_b),
    .bus (ifb.slave)
  );

  always #5 clk = ~clk;

  // Stimulus per instance
  bit          d_init_req [NI];
  bit          d_we0      [NI];
  bit          d_we1      [NI];
  int unsigned d_wn0      [NI];
  int unsigned d_wn1      [NI];
  logic [31:0] d_d0       [NI];
  logic [31:0] d_d1       [NI];
  int unsigned d_rn       [NI][3];

  assign ifa.init_req = d_init_req[0];
  assign ifa.we0      = d_we0[0];
  assign ifa.wn0      = 5'(d_wn0[0]);
  assign ifa.d0       = d_d0[0];
  assign ifa.we1      = d_we1[0];
  assign ifa.wn1      = 5'(d_wn1[0]);
  assign ifa.d1       = d_d1[0];
  assign ifa.rn       = {5'(d_rn[0][1]), 5'(d_rn[0][0])};

  assign ifb.init_req = d_init_req[1];
  assign ifb.we0      = d_we0[1];
  assign ifb.wn0      = 6'(d_wn0[1]);
  assign ifb.d0       = d_d0[1];
  assign ifb.we1      = d_we1[1];
  assign ifb.wn1      = 6'(d_wn1[1]);
  assign ifb.d1       = d_d1[1];
  assign ifb.rn       = {6'(d_rn[1][2]), 6'(d_rn[1][1]), 6'(d_rn[1][0])};

  // Reference model: architectural register contents plus init countdown
  int unsigned nreg_c   [NI] = '{32, 64};
  bit          bypass_c [NI] = '{1'b1, 1'b0};
  int unsigned nrd_c    [NI] = '{2, 3};
  logic [31:0] m_mem    [NI][64];
  bit          m_ready  [NI];
  int          m_left   [NI];
  bit          m_collide[NI];

  function automatic string nm(int i);
    return (i == 0) ? "a" : "b";
  endfunction

  function automatic bit clr_of(int i);
    return (i == 0) ? clr_a : clr_b;
  endfunction

  function automatic logic [31:0] dut_q(int i, int k);
    if (i == 0) return 32'(ifa.q >> (32 * k));
    return 32'(ifb.q >> (32 * k));
  endfunction

  function automatic logic [31:0] dut_ready(int i);
    return (i == 0) ? 32'(ifa.ready) : 32'(ifb.ready);
  endfunction

  function automatic logic [31:0] dut_collide(int i);
    return (i == 0) ? 32'(ifa.collide) : 32'(ifb.collide);
  endfunction

  function automatic void model_reset(int i);
    m_ready[i]   = 1'b0;
    m_left[i]    = int'(nreg_c[i]);
    m_collide[i] = 1'b0;
  endfunction

  // Effect of one rising edge on the model, from the inputs present before it.
  function automatic void model_edge(int i);
    bit v0, v1;
    if (clr_of(i)) begin
      model_reset(i);
      return;
    end
    v0 = m_ready[i] && d_we0[i] && (d_wn0[i] != 0);
    v1 = m_ready[i] && d_we1[i] && (d_wn1[i] != 0);
    m_collide[i] = v0 && v1 && (d_wn0[i] == d_wn1[i]);
    if (m_ready[i]) begin
      if (v0) m_mem[i][d_wn0[i]] = d_d0[i];
      if (v1) m_mem[i][d_wn1[i]] = d_d1[i];
      if (d_init_req[i]) begin
        m_ready[i] = 1'b0;
        m_left[i]  = int'(nreg_c[i]);
      end
    end else if (d_init_req[i]) begin
      m_left[i] = int'(nreg_c[i]);
    end else begin
      m_left[i] = m_left[i] - 1;
      if (m_left[i] == 0) begin
        m_ready[i] = 1'b1;
        for (int j = 0; j < 64; j++) m_mem[i][j] = '0;
      end
    end
  endfunction

  function automatic logic [31:0] exp_q(int i, int k);
    int unsigned r;
    r = d_rn[i][k];
    if (!m_ready[i] || r == 0) return '0;
    if (bypass_c[i]) begin
      if (d_we1[i] && d_wn1[i] == r) return d_d1[i];
      if (d_we0[i] && d_wn0[i] == r) return d_d0[i];
    end
    return m_mem[i][r];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_comb();
    for (int i = 0; i < int'(NI); i++)
      for (int k = 0; k < int'(nrd_c[i]); k++)
        chk($sformatf("%s.q%0d", nm(i), k), dut_q(i, k), exp_q(i, k));
  endtask

  task automatic check_regs();
    for (int i = 0; i < int'(NI); i++) begin
      chk($sformatf("%s.ready", nm(i)), dut_ready(i), 32'(m_ready[i]));
      chk($sformatf("%s.collide", nm(i)), dut_collide(i), 32'(m_collide[i]));
    end
  endtask

  task automatic quiet(int i);
    d_init_req[i] = 1'b0;
    d_we0[i]      = 1'b0;
    d_we1[i]      = 1'b0;
    d_wn0[i]      = 0;
    d_wn1[i]      = 0;
    d_d0[i]       = '0;
    d_d1[i]       = '0;
    for (int k = 0; k < 3; k++) d_rn[i][k] = 0;
  endtask

  // Inputs are set before calling; reads checked mid-cycle, state after the edge.
  task automatic cycle();
    #1;
    check_comb();
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic run_until_ready(input int i, input string tag, input int exp_n);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
      d_we0[i] = 1'b0;
      d_we1[i] = 1'b0;
    end while (dut_ready(i) == 0 && n < 200);
    chk(tag, 32'(n), 32'(exp_n));
  endtask

  initial begin
    quiet(0);
    quiet(1);
    clr_a = 1'b1;
    clr_b = 1'b1;
    model_reset(0);
    model_reset(1);
    @(posedge clk);
    #1;
    check_regs();
    #1;
    check_comb();
    chk("rst_ready_a", dut_ready(0), 32'd0);

    // 1: sweep after reset, then every entry reads zero
    clr_a = 1'b0;
    clr_b = 1'b0;
    run_until_ready(0, "t1_init_cycles", 32);
    for (int r = 0; r < 32; r++) begin
      d_rn[0][0] = r;
      d_rn[0][1] = 31 - r;
      cycle();
    end
    while (dut_ready(1) == 0 && m_left[1] > -5) cycle();
    chk("t1_ready_b", dut_ready(1), 32'd1);

    // 2: lane0 write visible same cycle through bypass, then from storage
    d_we0[0] = 1'b1; d_wn0[0] = 5; d_d0[0] = 32'hDEAD_BEEF; d_rn[0][0] = 5;
    #1;
    chk("t2_bypass", dut_q(0, 0), 32'hDEAD_BEEF);
    cycle();
    d_we0[0] = 1'b0;
    #1;
    chk("t2_stored", dut_q(0, 0), 32'hDEAD_BEEF);
    cycle();

    // 3: colliding lanes, lane1 wins; then collision on the zero entry is dropped
    d_we0[0] = 1'b1; d_wn0[0] = 7; d_d0[0] = 32'h1111;
    d_we1[0] = 1'b1; d_wn1[0] = 7; d_d1[0] = 32'h2222;
    d_rn[0][0] = 7;
    cycle();
    chk("t3_collide", dut_collide(0), 32'd1);
    d_we0[0] = 1'b0; d_we1[0] = 1'b0;
    #1;
    chk("t3_reg7", dut_q(0, 0), 32'h2222);
    cycle();
    chk("t3_collide_pulse", dut_collide(0), 32'd0);
    d_we0[0] = 1'b1; d_wn0[0] = 0; d_we1[0] = 1'b1; d_wn1[0] = 0; d_rn[0][0] = 0;
    cycle();
    chk("t3_zero_collide", dut_collide(0), 32'd0);
    d_we0[0] = 1'b0; d_we1[0] = 1'b0;
    #1;
    chk("t3_reg0", dut_q(0, 0), 32'd0);
    cycle();

    // 4: init_req clears contents; writes during the sweep are ignored
    d_we0[0] = 1'b1; d_wn0[0] = 3; d_d0[0] = 32'hA5A5_A5A5;
    cycle();
    d_we0[0] = 1'b0;
    d_init_req[0] = 1'b1;
    cycle();
    d_init_req[0] = 1'b0;
    chk("t4_ready_drop", dut_ready(0), 32'd0);
    d_we0[0] = 1'b1; d_wn0[0] = 4; d_d0[0] = 32'h1234_5678;
    run_until_ready(0, "t4_init_cycles", 32);
    d_rn[0][0] = 3; d_rn[0][1] = 4;
    #1;
    chk("t4_reg3", dut_q(0, 0), 32'd0);
    chk("t4_reg4", dut_q(0, 1), 32'd0);
    cycle();

    // 5: restart by init_req at cnt=10, then by clr at cnt=20
    d_init_req[0] = 1'b1;
    cycle();
    d_init_req[0] = 1'b0;
    repeat (10) cycle();
    d_init_req[0] = 1'b1;
    cycle();
    d_init_req[0] = 1'b0;
    repeat (20) cycle();
    chk("t5_busy", dut_ready(0), 32'd0);
    clr_a = 1'b1;
    model_reset(0);
    cycle();
    clr_a = 1'b0;
    run_until_ready(0, "t5_init_cycles", 32);

    // 6: no-bypass instance shows the new value one cycle late on all ports
    d_we0[1] = 1'b1; d_wn0[1] = 63; d_d0[1] = 32'h5;
    for (int k = 0; k < 3; k++) d_rn[1][k] = 63;
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("t6_old%0d", k), dut_q(1, k), 32'd0);
    cycle();
    d_we0[1] = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("t6_new%0d", k), dut_q(1, k), 32'h5);
    cycle();

    // Random traffic on both instances
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < int'(NI); i++) begin
        int unsigned top;
        top = nreg_c[i] - 1;
        d_init_req[i] = ($urandom_range(0, 79) == 0);
        d_we0[i] = $urandom_range(0, 1) == 1;
        d_we1[i] = $urandom_range(0, 1) == 1;
        d_wn0[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, top) : $urandom_range(0, 7);
        d_wn1[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, top) : $urandom_range(0, 7);
        d_d0[i]  = $urandom;
        d_d1[i]  = $urandom;
        for (int k = 0; k < 3; k++)
          d_rn[i][k] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, top) : $urandom_range(0, 7);
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
